// File: rtl/ukp_kbd_pkg.sv
// Shared constants for the USB boot-keyboard to ZX Spectrum matrix path:
// HID usage codes, matrix geometry, row/column indices and FSM encoding.
package ukp_kbd_pkg;

  localparam int unsigned NUM_ROWS  = 8;
  localparam int unsigned NUM_COLS  = 5;
  localparam int unsigned MATRIX_W  = NUM_ROWS * NUM_COLS;
  localparam int unsigned NUM_SLOTS = 6;

  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_A            = 8'h04;
  localparam logic [7:0] KEY_Z            = 8'h1D;
  localparam logic [7:0] KEY_1            = 8'h1E;
  localparam logic [7:0] KEY_9            = 8'h26;
  localparam logic [7:0] KEY_0            = 8'h27;
  localparam logic [7:0] KEY_ENTER        = 8'h28;
  localparam logic [7:0] KEY_ESC          = 8'h29;
  localparam logic [7:0] KEY_BKSP         = 8'h2A;
  localparam logic [7:0] KEY_SPACE        = 8'h2C;
  localparam logic [7:0] KEY_F12          = 8'h45;
  localparam logic [7:0] KEY_RIGHT        = 8'h4F;
  localparam logic [7:0] KEY_LEFT         = 8'h50;
  localparam logic [7:0] KEY_DOWN         = 8'h51;
  localparam logic [7:0] KEY_UP           = 8'h52;

  localparam logic [2:0] ROW_CS_V = 3'd0;
  localparam logic [2:0] ROW_A_G  = 3'd1;
  localparam logic [2:0] ROW_Q_T  = 3'd2;
  localparam logic [2:0] ROW_1_5  = 3'd3;
  localparam logic [2:0] ROW_0_6  = 3'd4;
  localparam logic [2:0] ROW_P_Y  = 3'd5;
  localparam logic [2:0] ROW_EN_H = 3'd6;
  localparam logic [2:0] ROW_SP_B = 3'd7;

  localparam logic [2:0] COL0 = 3'd0;
  localparam logic [2:0] COL1 = 3'd1;
  localparam logic [2:0] COL2 = 3'd2;
  localparam logic [2:0] COL3 = 3'd3;
  localparam logic [2:0] COL4 = 3'd4;

  localparam int unsigned IDX_CS = 0;   // r0c0 CAPS SHIFT
  localparam int unsigned IDX_SS = 36;  // r7c1 SYMBOL SHIFT

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_MOD, ST_COMMIT} state_e;

  function automatic logic [5:0] rc_index(logic [2:0] row, logic [2:0] col);
    return 6'(row) * 6'd5 + 6'(col);
  endfunction

endpackage

// File: rtl/ukp_zx_matrix_if.sv
// Report-in / matrix-out bundle between ukp2key, the matrix block and the ULA.
interface ukp_zx_matrix_if;
  logic [7:0]  key0, key1, key2, key3, key4, key5, key6;
  logic        new_packet;
  logic        conerr;
  logic [7:0]  row_sel;
  logic [4:0]  zx_kb;
  logic [39:0] key_matrix;
  logic        upd;
  logic        reset_req;

  modport master (
    output key0, key1, key2, key3, key4, key5, key6, new_packet, conerr, row_sel,
    input  zx_kb, key_matrix, upd, reset_req
  );

  modport slave (
    input  key0, key1, key2, key3, key4, key5, key6, new_packet, conerr, row_sel,
    output zx_kb, key_matrix, upd, reset_req
  );
endinterface

// File: rtl/hid_zx_decode.sv
// Maps one HID usage code to a ZX matrix position, plus whether the key
// also needs CAPS SHIFT (cursor keys, delete, break).
module hid_zx_decode
  import ukp_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic       valid,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       cs
);

  always_comb begin
    valid = 1'b1;
    cs    = 1'b0;
    row   = ROW_CS_V;
    col   = COL0;
    case (code)
      8'h04: {row, col} = {ROW_A_G,  COL0};
      8'h05: {row, col} = {ROW_SP_B, COL4};
      8'h06: {row, col} = {ROW_CS_V, COL3};
      8'h07: {row, col} = {ROW_A_G,  COL2};
      8'h08: {row, col} = {ROW_Q_T,  COL2};
      8'h09: {row, col} = {ROW_A_G,  COL3};
      8'h0A: {row, col} = {ROW_A_G,  COL4};
      8'h0B: {row, col} = {ROW_EN_H, COL4};
      8'h0C: {row, col} = {ROW_P_Y,  COL2};
      8'h0D: {row, col} = {ROW_EN_H, COL3};
      8'h0E: {row, col} = {ROW_EN_H, COL2};
      8'h0F: {row, col} = {ROW_EN_H, COL1};
      8'h10: {row, col} = {ROW_SP_B, COL2};
      8'h11: {row, col} = {ROW_SP_B, COL3};
      8'h12: {row, col} = {ROW_P_Y,  COL1};
      8'h13: {row, col} = {ROW_P_Y,  COL0};
      8'h14: {row, col} = {ROW_Q_T,  COL0};
      8'h15: {row, col} = {ROW_Q_T,  COL3};
      8'h16: {row, col} = {ROW_A_G,  COL1};
      8'h17: {row, col} = {ROW_Q_T,  COL4};
      8'h18: {row, col} = {ROW_P_Y,  COL3};
      8'h19: {row, col} = {ROW_CS_V, COL4};
      8'h1A: {row, col} = {ROW_Q_T,  COL1};
      8'h1B: {row, col} = {ROW_CS_V, COL2};
      8'h1C: {row, col} = {ROW_P_Y,  COL4};
      8'h1D: {row, col} = {ROW_CS_V, COL1};
      8'h1E: {row, col} = {ROW_1_5,  COL0};
      8'h1F: {row, col} = {ROW_1_5,  COL1};
      8'h20: {row, col} = {ROW_1_5,  COL2};
      8'h21: {row, col} = {ROW_1_5,  COL3};
      8'h22: {row, col} = {ROW_1_5,  COL4};
      8'h23: {row, col} = {ROW_0_6,  COL4};
      8'h24: {row, col} = {ROW_0_6,  COL3};
      8'h25: {row, col} = {ROW_0_6,  COL2};
      8'h26: {row, col} = {ROW_0_6,  COL1};
      KEY_0:     {row, col} = {ROW_0_6,  COL0};
      KEY_ENTER: {row, col} = {ROW_EN_H, COL0};
      KEY_SPACE: {row, col} = {ROW_SP_B, COL0};
      // Shifted specials: the base key plus CAPS SHIFT
      KEY_BKSP:  begin {row, col} = {ROW_0_6,  COL0}; cs = 1'b1; end
      KEY_ESC:   begin {row, col} = {ROW_SP_B, COL0}; cs = 1'b1; end
      KEY_LEFT:  begin {row, col} = {ROW_1_5,  COL4}; cs = 1'b1; end
      KEY_DOWN:  begin {row, col} = {ROW_0_6,  COL4}; cs = 1'b1; end
      KEY_UP:    begin {row, col} = {ROW_0_6,  COL3}; cs = 1'b1; end
      KEY_RIGHT: begin {row, col} = {ROW_0_6,  COL2}; cs = 1'b1; end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ukp_zx_matrix.sv
// Builds the ZX Spectrum 8x5 key matrix from a USB boot report, one slot per
// cycle into a shadow copy, then commits it atomically; serves ULA row reads.
module ukp_zx_matrix
  import ukp_kbd_pkg::*;
(
  input  logic           usbclk,
  input  logic           usbrst_n,
  ukp_zx_matrix_if.slave bus
);

  state_e                state_q;
  logic [2:0]            slot_q;
  logic [7:0]            snap_q [8];
  logic [7:0]            snap_in [8];
  logic [MATRIX_W-1:0]   shadow_q;
  logic [MATRIX_W-1:0]   km_q;
  logic                  np_q, pend_q, ovf_q, f12_q, upd_q, rr_q;
  logic                  ev;
  logic [7:0]            code;
  logic                  dec_valid, dec_cs;
  logic [2:0]            dec_row, dec_col;
  logic [5:0]            dec_idx;
  logic [NUM_COLS-1:0]   col_any;

  assign ev      = bus.new_packet != np_q;
  assign code    = snap_q[slot_q];
  assign dec_idx = rc_index(dec_row, dec_col);

  always_comb begin
    snap_in[0] = bus.key0;
    snap_in[1] = bus.key1;
    snap_in[2] = bus.key2;
    snap_in[3] = bus.key3;
    snap_in[4] = bus.key4;
    snap_in[5] = bus.key5;
    snap_in[6] = bus.key6;
    snap_in[7] = '0;
  end

  hid_zx_decode u_dec (
    .code  (code),
    .valid (dec_valid),
    .row   (dec_row),
    .col   (dec_col),
    .cs    (dec_cs)
  );

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= 3'd1;
      for (int i = 0; i < 8; i++) snap_q[i] <= '0;
      shadow_q <= '0;
      km_q     <= '0;
      np_q     <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      f12_q    <= 1'b0;
      upd_q    <= 1'b0;
      rr_q     <= 1'b0;
    end else begin
      np_q  <= bus.new_packet;
      upd_q <= 1'b0;
      if (bus.conerr) begin
        state_q <= ST_IDLE;
        pend_q  <= 1'b0;
        ovf_q   <= 1'b0;
        km_q    <= '0;
        rr_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ev) begin
              snap_q   <= snap_in;
              shadow_q <= '0;
              f12_q    <= 1'b0;
              slot_q   <= 3'd1;
              state_q  <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (ev) pend_q <= 1'b1;
            if (dec_valid) shadow_q[dec_idx] <= 1'b1;
            if (dec_cs)    shadow_q[IDX_CS]  <= 1'b1;
            if (code == KEY_ERR_ROLLOVER) ovf_q <= 1'b1;
            if (code == KEY_F12)          f12_q <= 1'b1;
            if (slot_q == 3'(NUM_SLOTS)) state_q <= ST_MOD;
            else                         slot_q  <= slot_q + 3'd1;
          end
          ST_MOD: begin
            if (ev) pend_q <= 1'b1;
            shadow_q[IDX_CS] <= shadow_q[IDX_CS] | snap_q[0][1] | snap_q[0][5];
            shadow_q[IDX_SS] <= shadow_q[IDX_SS] | snap_q[0][0] | snap_q[0][4];
            state_q <= ST_COMMIT;
          end
          ST_COMMIT: begin
            if (!ovf_q) begin
              km_q  <= shadow_q;
              rr_q  <= f12_q;
              upd_q <= 1'b1;
            end
            ovf_q <= 1'b0;
            // A toggle seen while busy (or right now) restarts from live inputs
            if (pend_q || ev) begin
              snap_q   <= snap_in;
              shadow_q <= '0;
              f12_q    <= 1'b0;
              slot_q   <= 3'd1;
              pend_q   <= 1'b0;
              state_q  <= ST_SCAN;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Active-low row select; a column reads low if any selected row has it pressed
  always_comb begin
    col_any = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (!bus.row_sel[r]) col_any[c] = col_any[c] | km_q[r*NUM_COLS + c];
      end
    end
  end

  assign bus.zx_kb      = ~col_any;
  assign bus.key_matrix = km_q;
  assign bus.upd        = upd_q;
  assign bus.reset_req  = rr_q;

endmodule

// File: tb/tb_ukp_zx_matrix.sv
// Scoreboard bench for ukp_zx_matrix: reports are modelled from the key layout
// table, expected commits are queued with their due cycle and checked on upd.
module tb_ukp_zx_matrix;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ukp_zx_matrix_if bus ();

  ukp_zx_matrix dut (
    .usbclk   (clk),
    .usbrst_n (rst_n),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          at;
    logic [39:0] km;
    bit          rr;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  string       rows [8];
  logic [39:0] last_km = '0;
  bit          last_rr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pos_of(input byte ch);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (rows[r][c] == ch) return r * 5 + c;
    return 0;
  endfunction

  function automatic void hid_map(input logic [7:0] code, output byte ch, output bit cs);
    cs = 1'b0;
    ch = 8'h00;
    if (code >= 8'h04 && code <= 8'h1D)      ch = byte'(8'h41 + code - 8'h04);
    else if (code >= 8'h1E && code <= 8'h26) ch = byte'(8'h31 + code - 8'h1E);
    else begin
      case (code)
        8'h27: ch = "0";
        8'h28: ch = "~";
        8'h2C: ch = "_";
        8'h2A: begin ch = "0"; cs = 1'b1; end
        8'h29: begin ch = "_"; cs = 1'b1; end
        8'h50: begin ch = "5"; cs = 1'b1; end
        8'h51: begin ch = "6"; cs = 1'b1; end
        8'h52: begin ch = "7"; cs = 1'b1; end
        8'h4F: begin ch = "8"; cs = 1'b1; end
        default: ch = 8'h00;
      endcase
    end
  endfunction

  function automatic void model(input logic [7:0] mods, input logic [47:0] keys,
                                output logic [39:0] km, output bit rr, output bit ovf);
    logic [7:0] k;
    byte        ch;
    bit         cs;
    km = '0; rr = 1'b0; ovf = 1'b0;
    for (int s = 0; s < 6; s++) begin
      k = keys[s*8 +: 8];
      if (k == 8'h01) ovf = 1'b1;
      if (k == 8'h45) rr = 1'b1;
      hid_map(k, ch, cs);
      if (ch != 8'h00) km[pos_of(ch)] = 1'b1;
      if (cs) km[pos_of("^")] = 1'b1;
    end
    if (mods[1] | mods[5]) km[pos_of("^")] = 1'b1;
    if (mods[0] | mods[4]) km[pos_of("*")] = 1'b1;
  endfunction

  function automatic logic [4:0] zx_model(input logic [39:0] km, input logic [7:0] rs);
    logic [4:0] pressed = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!rs[r] && km[r*5 + c]) pressed[c] = 1'b1;
    return ~pressed;
  endfunction

  function automatic logic [7:0] rand_code();
    int r = $urandom_range(0, 19);
    if (r < 5)   return 8'h00;
    if (r < 14)  return 8'($urandom_range(8'h04, 8'h2C));
    if (r < 16)  return 8'($urandom_range(8'h4F, 8'h52));
    if (r == 16) return 8'h45;
    if (r == 17) return 8'h01;
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [47:0] rand_keys();
    logic [47:0] k;
    for (int s = 0; s < 6; s++) k[s*8 +: 8] = rand_code();
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drive(input logic [7:0] mods, input logic [47:0] keys);
    bus.key0 = mods;
    bus.key1 = keys[7:0];
    bus.key2 = keys[15:8];
    bus.key3 = keys[23:16];
    bus.key4 = keys[31:24];
    bus.key5 = keys[39:32];
    bus.key6 = keys[47:40];
  endtask

  task automatic toggle();
    bus.new_packet = ~bus.new_packet;
  endtask

  task automatic expect_report(input int at, input logic [7:0] mods, input logic [47:0] keys);
    logic [39:0] km;
    bit rr, ovf;
    model(mods, keys, km, rr, ovf);
    if (!ovf) begin
      sb.push_back('{at: at, km: km, rr: rr});
      last_km = km;
      last_rr = rr;
    end
  endtask

  task automatic send(input logic [7:0] mods, input logic [47:0] keys);
    int k = cyc;
    drive(mods, keys);
    toggle();
    expect_report(k + 9, mods, keys);
    wait_until(k + 12);
  endtask

  task automatic check_zx_random(input string name);
    logic [7:0] rs = 8'($urandom);
    bus.row_sel = rs;
    #1;
    check(name, 64'(bus.zx_kb), 64'(zx_model(last_km, rs)));
  endtask

  // Monitor: every upd pulse must match the head of the scoreboard, on time
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.upd) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_upd: got upd=1 with key_matrix=%0h, expected no update (cycle %0d)",
                   bus.key_matrix, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("upd_cycle", 64'(cyc), 64'(mon_e.at));
          check("key_matrix", 64'(bus.key_matrix), 64'(mon_e.km));
          check("reset_req", 64'(bus.reset_req), 64'(mon_e.rr));
        end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL upd_missing: got no upd at cycle %0d, expected upd with key_matrix=%0h",
                 cyc, mon_e.km);
      end
    end
  end

  initial begin
    int k, t0, n, j;
    logic [7:0]  m;
    logic [47:0] kk;

    rows = '{"^ZXCV", "ASDFG", "QWERT", "12345", "09876", "POIUY", "~LKJH", "_*MNB"};
    drive(8'h00, 48'h0);
    bus.new_packet = 1'b0;
    bus.conerr     = 1'b0;
    bus.row_sel    = 8'h00;
    #1;
    check("rst_key_matrix", 64'(bus.key_matrix), 64'h0);
    check("rst_upd", 64'(bus.upd), 64'h0);
    check("rst_reset_req", 64'(bus.reset_req), 64'h0);
    check("rst_zx_kb", 64'(bus.zx_kb), 64'h1F);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single letter A
    send(8'h00, 48'h04);
    check("a_bit5", 64'(bus.key_matrix[5]), 64'h1);
    bus.row_sel = 8'hFD; #1;
    check("a_zx_row1", 64'(bus.zx_kb), 64'h1E);

    // LShift + Left arrow
    send(8'h02, 48'h50);
    check("cs5_bits", 64'(bus.key_matrix), 64'h80001);
    bus.row_sel = 8'hFE; #1;
    check("cs5_zx_row0", 64'(bus.zx_kb), 64'h1E);
    bus.row_sel = 8'h00; #1;
    check("cs5_zx_all", 64'(bus.zx_kb), 64'h0E);

    // Rollover report keeps the previous matrix
    send(8'h00, 48'h04);
    send(8'h00, 48'h010101010101);
    check("ovf_hold", 64'(bus.key_matrix), 64'h20);

    // Back-to-back with collapsed toggles; second commit uses inputs at E+8
    k = cyc;
    drive(8'h00, 48'h14); toggle();
    expect_report(k + 9, 8'h00, 48'h14);
    wait_until(k + 3); drive(8'h00, 48'h1D); toggle();
    wait_until(k + 4); toggle();
    wait_until(k + 8); drive(8'h10, 48'h2C28);
    expect_report(k + 17, 8'h10, 48'h2C28);
    wait_until(k + 22);
    check("b2b_final", 64'(bus.key_matrix), 64'(last_km));

    // F12 then connection error
    send(8'h00, 48'h45);
    check("f12_reset_req", 64'(bus.reset_req), 64'h1);
    bus.conerr = 1'b1;
    tick();
    check("conerr_km", 64'(bus.key_matrix), 64'h0);
    check("conerr_rr", 64'(bus.reset_req), 64'h0);
    last_km = '0; last_rr = 1'b0;
    toggle(); tick(); toggle(); tick(); toggle();
    repeat (12) tick();
    bus.conerr = 1'b0;
    repeat (12) tick();
    check("conerr_release_km", 64'(bus.key_matrix), 64'h0);

    // Asynchronous reset in the middle of a scan
    send(8'h00, 48'h04);
    k = cyc;
    drive(8'h00, 48'h05); toggle();
    wait_until(k + 3);
    rst_n = 1'b0;
    #1;
    check("midrst_km", 64'(bus.key_matrix), 64'h0);
    check("midrst_upd", 64'(bus.upd), 64'h0);
    check("midrst_rr", 64'(bus.reset_req), 64'h0);
    bus.new_packet = 1'b0;
    last_km = '0; last_rr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(8'h00, 48'h06);
    check("post_rst_c", 64'(bus.key_matrix), 64'h8);

    // Random isolated reports
    for (int i = 0; i < 40; i++) begin
      m  = 8'($urandom);
      kk = rand_keys();
      send(m, kk);
      check("rand_km_hold", 64'(bus.key_matrix), 64'(last_km));
      check_zx_random("rand_zx_kb");
    end

    // Random back-to-back bursts
    for (int i = 0; i < 12; i++) begin
      k = cyc;
      m = 8'($urandom); kk = rand_keys();
      drive(m, kk); toggle();
      expect_report(k + 9, m, kk);
      t0 = $urandom_range(1, 5);
      n  = $urandom_range(1, 3);
      for (int t = 0; t < n; t++) begin
        wait_until(k + t0 + t);
        drive(8'($urandom), rand_keys());
        toggle();
      end
      j = $urandom_range(k + t0 + n - 1, k + 8);
      wait_until(j);
      m = 8'($urandom); kk = rand_keys();
      drive(m, kk);
      expect_report(k + 17, m, kk);
      wait_until(k + 21);
      check_zx_random("b2b_zx_kb");
    end

    repeat (20) tick();
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
